// File: rtl/regfile_write_buffer.sv
// Posted-write FIFO in front of the regfile write port, with read forwarding of queued data.
// Latency: accept->regfile write 1 cycle min; forwarding is combinational. InReady drops only when full.
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          InValid,
    output logic          InReady,
    input  logic [AW-1:0] InRegister,
    input  logic [DW-1:0] InData,
    input  logic          PortBusy,
    output logic [AW-1:0] WriteRegister,
    output logic [DW-1:0] WriteData,
    output logic          RegWrite,
    input  logic [AW-1:0] LookupRegister1,
    input  logic [AW-1:0] LookupRegister2,
    output logic          FwdHit1,
    output logic          FwdHit2,
    output logic [DW-1:0] FwdData1,
    output logic [DW-1:0] FwdData2,
    output logic [AW-1:0] Count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] ent_reg_q  [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] last_reg_q;
    logic [DW-1:0] last_data_q;

    logic push, pop, empty, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Register 0 still completes the handshake but is never stored.
    assign InReady = !full;
    assign push    = InValid && !full && (InRegister != '0);
    assign pop     = !empty && !PortBusy;

    assign RegWrite      = pop;
    assign WriteRegister = empty ? last_reg_q  : ent_reg_q[rd_ptr_q];
    assign WriteData     = empty ? last_data_q : ent_data_q[rd_ptr_q];
    assign Count         = AW'(count_q);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            last_reg_q  <= '0;
            last_data_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (pop) begin
                last_reg_q  <= ent_reg_q[rd_ptr_q];
                last_data_q <= ent_data_q[rd_ptr_q];
            end
        end
    end

    // Entry storage needs no reset: validity comes from rd_ptr/count.
    always_ff @(posedge Clk) begin
        if (push) begin
            ent_reg_q[wr_ptr_q]  <= InRegister;
            ent_data_q[wr_ptr_q] <= InData;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] addr);
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (addr != '0) && (ent_reg_q[idx] == addr))
                res = {1'b1, ent_data_q[idx]};
        end
        return res;
    endfunction

    always_comb begin
        {FwdHit1, FwdData1} = fwd_lookup(LookupRegister1);
        {FwdHit2, FwdData2} = fwd_lookup(LookupRegister2);
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed vector table, reset/steady-state sequences,
// and random traffic against a queue-based reference model of the buffer plus regfile.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          Clk = 1'b0;
    logic          ResetN;
    logic          InValid;
    logic          InReady;
    logic [AW-1:0] InRegister;
    logic [DW-1:0] InData;
    logic          PortBusy;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [AW-1:0] LookupRegister1, LookupRegister2;
    logic          FwdHit1, FwdHit2;
    logic [DW-1:0] FwdData1, FwdData2;
    logic [AW-1:0] Count;

    regfile_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .InValid(InValid), .InReady(InReady), .InRegister(InRegister), .InData(InData),
        .PortBusy(PortBusy),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .LookupRegister1(LookupRegister1), .LookupRegister2(LookupRegister2),
        .FwdHit1(FwdHit1), .FwdHit2(FwdHit2), .FwdData1(FwdData1), .FwdData2(FwdData2),
        .Count(Count)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Regfile fed by the DUT's write port (r0 hardwired to zero).
    logic [DW-1:0] dut_rf [32] = '{default: '0};
    always @(posedge Clk) begin
        if (RegWrite && WriteRegister != '0) dut_rf[WriteRegister] = WriteData;
    end

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    ent_t          mlast;
    logic [DW-1:0] mrf [32] = '{default: '0};

    typedef struct {
        logic          valid;
        logic [AW-1:0] rg;
        logic [DW-1:0] dat;
        logic          busy;
        logic [AW-1:0] lk1, lk2;
        logic          rdy, rw;
        logic [AW-1:0] wreg;
        logic [DW-1:0] wdat;
        logic          h1;
        logic [DW-1:0] f1;
        logic          h2;
        logic [DW-1:0] f2;
        logic [AW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int v, input int rg, input int dat, input int busy, input int lk1,
                       input int lk2, input int rdy, input int rw, input int wreg, input int wdat,
                       input int h1, input int f1, input int h2, input int f2, input int cnt);
        vec_t e;
        e.valid = (v != 0);    e.rg = AW'(rg);     e.dat = DW'(dat);  e.busy = (busy != 0);
        e.lk1 = AW'(lk1);      e.lk2 = AW'(lk2);   e.rdy = (rdy != 0); e.rw = (rw != 0);
        e.wreg = AW'(wreg);    e.wdat = DW'(wdat); e.h1 = (h1 != 0);  e.f1 = DW'(f1);
        e.h2 = (h2 != 0);      e.f2 = DW'(f2);     e.cnt = AW'(cnt);
        vecs.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                         input logic b, input logic [AW-1:0] l1, input logic [AW-1:0] l2);
        InValid = v; InRegister = r; InData = d; PortBusy = b;
        LookupRegister1 = l1; LookupRegister2 = l2;
    endtask

    task automatic model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] dat);
        hit = 1'b0; dat = '0;
        if (a != '0) begin
            foreach (mq[i]) if (mq[i].r == a) begin hit = 1'b1; dat = mq[i].d; end
        end
    endtask

    task automatic model_check(input string tag);
        logic h1, h2;
        logic [DW-1:0] f1, f2;
        model_fwd(LookupRegister1, h1, f1);
        model_fwd(LookupRegister2, h2, f2);
        check({tag, "_ready"}, InReady, mq.size() != DEPTH);
        check({tag, "_regwrite"}, RegWrite, (mq.size() != 0) && !PortBusy);
        check({tag, "_wreg"}, WriteRegister, (mq.size() != 0) ? mq[0].r : mlast.r);
        check({tag, "_wdata"}, WriteData, (mq.size() != 0) ? mq[0].d : mlast.d);
        check({tag, "_hit1"}, FwdHit1, h1);
        check({tag, "_fwd1"}, FwdData1, f1);
        check({tag, "_hit2"}, FwdHit2, h2);
        check({tag, "_fwd2"}, FwdData2, f2);
        check({tag, "_count"}, Count, mq.size());
    endtask

    // Applies the rising edge that follows, using the inputs currently driven.
    task automatic model_step();
        bit   do_pop, do_push;
        ent_t e;
        do_pop  = (mq.size() != 0) && !PortBusy;
        do_push = InValid && (mq.size() != DEPTH) && (InRegister != '0);
        if (do_pop) begin
            mrf[mq[0].r] = mq[0].d;
            mlast = mq.pop_front();
        end
        if (do_push) begin
            e.r = InRegister; e.d = InData;
            mq.push_back(e);
        end
    endtask

    task automatic cycle(input string tag, input logic v, input logic [AW-1:0] r,
                         input logic [DW-1:0] d, input logic b,
                         input logic [AW-1:0] l1, input logic [AW-1:0] l2);
        drive(v, r, d, b, l1, l2);
        @(negedge Clk);
        model_check(tag);
        model_step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        mlast.r = '0; mlast.d = '0;
        ResetN = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 5'd0, 5'd0);
        #2;
        check("rst_ready", InReady, 1'b1);
        check("rst_regwrite", RegWrite, 1'b0);
        check("rst_count", Count, 0);
        check("rst_hit1", FwdHit1, 1'b0);
        #10 ResetN = 1'b1;
        @(posedge Clk); #1;

        //   v rg dat b lk1 lk2 | rdy rw wreg wdat h1 f1 h2 f2 cnt
        add(1, 2, 42, 0, 2, 4,   1, 0, 0, 0,   0, 0,  0, 0,  0);
        add(0, 0, 0,  0, 2, 4,   1, 1, 2, 42,  1, 42, 0, 0,  1);
        add(0, 0, 0,  1, 2, 4,   1, 0, 2, 42,  0, 0,  0, 0,  0);
        add(1, 3, 26, 1, 3, 4,   1, 0, 2, 42,  0, 0,  0, 0,  0);
        add(1, 4, 23, 1, 3, 4,   1, 0, 3, 26,  1, 26, 0, 0,  1);
        add(1, 5, 7,  1, 5, 4,   1, 0, 3, 26,  0, 0,  1, 23, 2);
        add(1, 6, 9,  1, 5, 4,   1, 0, 3, 26,  1, 7,  1, 23, 3);
        add(1, 8, 55, 1, 6, 4,   0, 0, 3, 26,  1, 9,  1, 23, 4);
        add(0, 0, 0,  0, 8, 4,   0, 1, 3, 26,  0, 0,  1, 23, 4);
        add(0, 0, 0,  0, 3, 4,   1, 1, 4, 23,  0, 0,  1, 23, 3);
        add(0, 0, 0,  0, 5, 4,   1, 1, 5, 7,   1, 7,  0, 0,  2);
        add(0, 0, 0,  0, 6, 4,   1, 1, 6, 9,   1, 9,  0, 0,  1);
        add(1, 7, 11, 1, 7, 4,   1, 0, 6, 9,   0, 0,  0, 0,  0);
        add(1, 7, 99, 1, 7, 4,   1, 0, 7, 11,  1, 11, 0, 0,  1);
        add(1, 0, 19, 1, 7, 0,   1, 0, 7, 11,  1, 99, 0, 0,  2);
        add(0, 0, 0,  1, 0, 0,   1, 0, 7, 11,  0, 0,  0, 0,  2);
        add(0, 0, 0,  0, 7, 4,   1, 1, 7, 11,  1, 99, 0, 0,  2);
        add(0, 0, 0,  0, 7, 4,   1, 1, 7, 99,  1, 99, 0, 0,  1);
        add(0, 0, 0,  0, 7, 4,   1, 0, 7, 99,  0, 0,  0, 0,  0);

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rg, vecs[i].dat, vecs[i].busy, vecs[i].lk1, vecs[i].lk2);
            @(negedge Clk);
            check($sformatf("row%0d_ready", i), InReady, vecs[i].rdy);
            check($sformatf("row%0d_regwrite", i), RegWrite, vecs[i].rw);
            check($sformatf("row%0d_wreg", i), WriteRegister, vecs[i].wreg);
            check($sformatf("row%0d_wdata", i), WriteData, vecs[i].wdat);
            check($sformatf("row%0d_hit1", i), FwdHit1, vecs[i].h1);
            check($sformatf("row%0d_fwd1", i), FwdData1, vecs[i].f1);
            check($sformatf("row%0d_hit2", i), FwdHit2, vecs[i].h2);
            check($sformatf("row%0d_fwd2", i), FwdData2, vecs[i].f2);
            check($sformatf("row%0d_count", i), Count, vecs[i].cnt);
            model_step();
            @(posedge Clk); #1;
        end
        check("tbl_rf_r2", dut_rf[2], 42);
        check("tbl_rf_r6", dut_rf[6], 9);
        check("tbl_rf_r7", dut_rf[7], 99);
        check("tbl_rf_r8", dut_rf[8], 0);

        // Steady state: two entries, push and pop every cycle.
        cycle("fill0", 1'b1, 5'd10, 32'h100, 1'b1, 5'd10, 5'd11);
        cycle("fill1", 1'b1, 5'd11, 32'h101, 1'b1, 5'd10, 5'd11);
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("steady%0d", i), 1'b1, AW'(12 + i), DW'(32'h200 + i), 1'b0,
                  AW'(11 + i), AW'(12 + i));
            check($sformatf("steady%0d_hold2", i), Count, 2);
        end
        for (int i = 0; i < 3; i++) cycle("drain", 1'b0, '0, '0, 1'b0, 5'd17, 5'd16);

        // Reset asserted between edges while entries are queued.
        cycle("pre0", 1'b1, 5'd20, 32'hA0, 1'b1, 5'd21, 5'd22);
        cycle("pre1", 1'b1, 5'd21, 32'hA1, 1'b1, 5'd21, 5'd22);
        cycle("pre2", 1'b1, 5'd22, 32'hA2, 1'b1, 5'd21, 5'd22);
        drive(1'b0, '0, '0, 1'b0, 5'd21, 5'd22);
        @(negedge Clk);
        model_check("middrain");
        #2 ResetN = 1'b0;
        #1;
        check("arst_regwrite", RegWrite, 1'b0);
        check("arst_count", Count, 0);
        check("arst_ready", InReady, 1'b1);
        check("arst_hit1", FwdHit1, 1'b0);
        check("arst_fwd2", FwdData2, 0);
        mq.delete();
        mlast.r = '0; mlast.d = '0;
        @(posedge Clk); #3;
        ResetN = 1'b1;
        @(posedge Clk); #1;
        check("arst_rf_r21", dut_rf[21], 0);
        check("arst_rf_r22", dut_rf[22], 0);

        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), DW'($urandom),
                  ($urandom_range(0, 9) < 3), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle("final_drain", 1'b0, '0, '0, 1'b0, 5'd1, 5'd2);

        for (int r = 0; r < 32; r++) check($sformatf("rf_r%0d", r), dut_rf[r], mrf[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
